// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - shared types, encodings and call-evaluation helpers for the car controller
package ascensor_pkg;

    // Widest car the helper functions can evaluate; call vectors are zero-extended to this width.
    localparam int MAX_PISOS  = 32;
    localparam int PISO_W_MAX = $clog2(MAX_PISOS);

    typedef enum logic [2:0] {
        REPOSO,
        MOVIENDO,
        ABRIENDO,
        ABIERTA,
        CERRANDO
    } estado_t;

    localparam logic [1:0] PUERTAS_CERRADAS  = 2'b00;
    localparam logic [1:0] PUERTAS_ABIERTAS  = 2'b01;
    localparam logic [1:0] PUERTAS_ABRIENDO  = 2'b10;
    localparam logic [1:0] PUERTAS_CERRANDO  = 2'b11;

    localparam logic DIR_SUBE = 1'b1;
    localparam logic DIR_BAJA = 1'b0;

    // Any pending call strictly above floor 'piso'.
    function automatic logic hay_llamadas_arriba(input logic [MAX_PISOS-1:0]  llamadas,
                                                 input logic [PISO_W_MAX-1:0] piso);
        logic [PISO_W_MAX:0] desplaza;
        desplaza = {1'b0, piso} + (PISO_W_MAX+1)'(1);
        return |(llamadas >> desplaza);
    endfunction

    // Any pending call strictly below floor 'piso'.
    function automatic logic hay_llamadas_abajo(input logic [MAX_PISOS-1:0]  llamadas,
                                                input logic [PISO_W_MAX-1:0] piso);
        logic [MAX_PISOS-1:0] mascara;
        mascara = (MAX_PISOS'(1) << piso) - MAX_PISOS'(1);
        return |(llamadas & mascara);
    endfunction

    // A moving car stops at 'piso' for a car call, a hall call in its travel direction,
    // or an opposite hall call when nothing is waiting further along.
    function automatic logic piso_servido(input logic [MAX_PISOS-1:0]  cab,
                                          input logic [MAX_PISOS-1:0]  sube,
                                          input logic [MAX_PISOS-1:0]  baja,
                                          input logic [PISO_W_MAX-1:0] piso,
                                          input logic                  dir,
                                          input logic                  arriba,
                                          input logic                  abajo);
        if (dir == DIR_SUBE)
            return cab[piso] | sube[piso] | (baja[piso] & ~arriba);
        else
            return cab[piso] | baja[piso] | (sube[piso] & ~abajo);
    endfunction

endpackage

// File: rtl/temporizador_ascensor.sv
// rtl/temporizador_ascensor.sv - loadable down-counter with expiry flag for travel and door timing
module temporizador_ascensor #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         carga,
    input  logic [W-1:0] valor,
    output logic         expirado
);

    logic [W-1:0] cuenta;

    // Load takes priority; otherwise count down and rest at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cuenta <= '0;
        else if (carga)
            cuenta <= valor;
        else if (cuenta != '0)
            cuenta <= cuenta - W'(1);
    end

    assign expirado = (cuenta == '0);

endmodule

// File: rtl/control_ascensor_param.sv
// rtl/control_ascensor_param.sv - single-car SCAN controller; ASCENSOR_EMERGENCIA_EN adds recall to floor 0
module control_ascensor_param
    import ascensor_pkg::*;
#(
    parameter int N_PISOS   = 4,
    parameter int T_VIAJE   = 8,
    parameter int T_PUERTA  = 4,
    parameter int T_ABIERTA = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PISOS-1:0]         llamada_sube,
    input  logic [N_PISOS-1:0]         llamada_baja,
    input  logic [N_PISOS-1:0]         llamada_cabina,
    input  logic                       boton_abrir,
    input  logic                       boton_cerrar,
    input  logic                       sensor,
`ifdef ASCENSOR_EMERGENCIA_EN
    input  logic                       emergencia,
`endif
    output logic [N_PISOS-1:0]         luces_sube,
    output logic [N_PISOS-1:0]         luces_baja,
    output logic [N_PISOS-1:0]         luces_cabina,
    output logic [$clog2(N_PISOS)-1:0] piso_actual,
    output logic                       direccion,
    output logic                       moviendo,
    output logic [1:0]                 puertas,
    output logic [N_PISOS-1:0]         aviso
);

    localparam int PW    = $clog2(N_PISOS);
    localparam int T_MAX = (T_VIAJE > T_PUERTA) ? ((T_VIAJE > T_ABIERTA) ? T_VIAJE : T_ABIERTA)
                                                : ((T_PUERTA > T_ABIERTA) ? T_PUERTA : T_ABIERTA);
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [PW-1:0]      PISO_MAX     = PW'(N_PISOS - 1);
    localparam logic [N_PISOS-1:0] UNO          = N_PISOS'(1);
    localparam logic [N_PISOS-1:0] MASCARA_SUBE = {1'b0, {(N_PISOS-1){1'b1}}};
    localparam logic [N_PISOS-1:0] MASCARA_BAJA = {{(N_PISOS-1){1'b1}}, 1'b0};

    estado_t             estado, estado_sig;
    logic [PW-1:0]       piso_sig, p_eval;
    logic                dir_sig, d_eval, dir_nueva;
    logic                carga, expirado, entra_servicio, represion;
    logic [TW-1:0]       valor;
    logic                arriba, abajo, aqui, servido, sin_mas, emerg;
    logic [N_PISOS-1:0]  oh_eval, limpia_cab, limpia_sube, limpia_baja;
    logic [N_PISOS-1:0]  bloq_cab, bloq_sube, bloq_baja;
    logic [MAX_PISOS-1:0]  cab_x, sube_x, baja_x;
    logic [PISO_W_MAX-1:0] p_x;

`ifdef ASCENSOR_EMERGENCIA_EN
    assign emerg = emergencia;
`else
    assign emerg = 1'b0;
`endif

    temporizador_ascensor #(.W(TW)) u_temporizador (
        .clk      (clk),
        .rst      (rst),
        .carga    (carga),
        .valor    (valor),
        .expirado (expirado)
    );

    // Floor and direction the current decision refers to: the next floor on travel expiry.
    always_comb begin
        p_eval = piso_actual;
        d_eval = direccion;
        if (estado == MOVIENDO && expirado) begin
            if (direccion == DIR_SUBE && piso_actual != PISO_MAX)
                p_eval = piso_actual + PW'(1);
            else if (direccion == DIR_BAJA && piso_actual != '0)
                p_eval = piso_actual - PW'(1);
            if (p_eval == '0)
                d_eval = DIR_SUBE;
            else if (p_eval == PISO_MAX)
                d_eval = DIR_BAJA;
            if (emerg)
                d_eval = DIR_BAJA;
        end
    end

    // Widen latched calls and floor index for the shared helper functions.
    always_comb begin
        cab_x  = '0;
        sube_x = '0;
        baja_x = '0;
        p_x    = '0;
        cab_x[N_PISOS-1:0]  = luces_cabina;
        sube_x[N_PISOS-1:0] = luces_sube;
        baja_x[N_PISOS-1:0] = luces_baja;
        p_x[PW-1:0]         = p_eval;
    end

    assign arriba    = hay_llamadas_arriba(cab_x | sube_x | baja_x, p_x);
    assign abajo     = hay_llamadas_abajo(cab_x | sube_x | baja_x, p_x);
    assign aqui      = cab_x[p_x] | sube_x[p_x] | baja_x[p_x];
    assign servido   = piso_servido(cab_x, sube_x, baja_x, p_x, d_eval, arriba, abajo);
    assign sin_mas   = ~arriba & ~abajo;
    assign oh_eval   = UNO << p_eval;
    // Direction the car will leave in once the doors close; decides which hall call is served.
    assign dir_nueva = (d_eval == DIR_SUBE) ? ((arriba | ~abajo) ? DIR_SUBE : DIR_BAJA)
                                            : ((abajo | ~arriba) ? DIR_BAJA : DIR_SUBE);

    // Calls just served at this floor are not relatched while the doors are open or opening.
    always_comb begin
        bloq_cab  = '0;
        bloq_sube = '0;
        bloq_baja = '0;
        if (estado == ABRIENDO || estado == ABIERTA) begin
            bloq_cab = oh_eval;
            if (direccion == DIR_SUBE || sin_mas) bloq_sube = oh_eval;
            if (direccion == DIR_BAJA || sin_mas) bloq_baja = oh_eval;
        end
    end

    assign represion = |(llamada_cabina & bloq_cab) | |(llamada_sube & MASCARA_SUBE & bloq_sube)
                     | |(llamada_baja & MASCARA_BAJA & bloq_baja);

    // Next state, timer loads and call clearing.
    always_comb begin
        estado_sig     = estado;
        piso_sig       = piso_actual;
        dir_sig        = direccion;
        carga          = 1'b0;
        valor          = '0;
        entra_servicio = 1'b0;
        case (estado)
            REPOSO: begin
                if (emerg ? (piso_actual == '0) : aqui) begin
                    entra_servicio = 1'b1;
                end else if (emerg || arriba || abajo) begin
                    estado_sig = MOVIENDO;
                    carga      = 1'b1;
                    valor      = TW'(T_VIAJE - 1);
                    if (!(arriba && abajo)) dir_sig = arriba ? DIR_SUBE : DIR_BAJA;
                end
            end
            MOVIENDO: begin
                if (expirado) begin
                    piso_sig = p_eval;
                    dir_sig  = d_eval;
                    if (emerg ? (p_eval == '0) : servido) begin
                        entra_servicio = 1'b1;
                    end else begin
                        carga = 1'b1;
                        valor = TW'(T_VIAJE - 1);
                    end
                end
            end
            ABRIENDO: begin
                if (expirado) begin
                    estado_sig = ABIERTA;
                    carga      = 1'b1;
                    valor      = TW'(T_ABIERTA - 1);
                end
            end
            ABIERTA: begin
                if (emerg) begin
                    // Recall: hold open at floor 0, elsewhere close as soon as the way is clear.
                    if (piso_actual == '0) begin
                        carga = 1'b1;
                        valor = TW'(T_ABIERTA - 1);
                    end else if (!sensor) begin
                        estado_sig = CERRANDO;
                        carga      = 1'b1;
                        valor      = TW'(T_PUERTA - 1);
                    end
                end else if (boton_abrir || represion || (sensor && !expirado)) begin
                    carga = 1'b1;
                    valor = TW'(T_ABIERTA - 1);
                end else if (!sensor && (boton_cerrar || expirado)) begin
                    estado_sig = CERRANDO;
                    carga      = 1'b1;
                    valor      = TW'(T_PUERTA - 1);
                end
            end
            CERRANDO: begin
                if (sensor || (boton_abrir && !emerg)) begin
                    estado_sig = ABRIENDO;
                    carga      = 1'b1;
                    valor      = TW'(T_PUERTA - 1);
                end else if (expirado) begin
                    estado_sig = REPOSO;
                end
            end
            default: estado_sig = REPOSO;
        endcase
        if (entra_servicio) begin
            estado_sig = ABRIENDO;
            carga      = 1'b1;
            valor      = TW'(T_PUERTA - 1);
            dir_sig    = dir_nueva;
        end
        if (emerg && !(estado == MOVIENDO && !expirado))
            dir_sig = DIR_BAJA;
    end

    assign limpia_cab  = entra_servicio ? oh_eval : '0;
    assign limpia_sube = (entra_servicio && (dir_nueva == DIR_SUBE || sin_mas)) ? oh_eval : '0;
    assign limpia_baja = (entra_servicio && (dir_nueva == DIR_BAJA || sin_mas)) ? oh_eval : '0;

    // State, position, direction, call lights and chime registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado       <= REPOSO;
            piso_actual  <= '0;
            direccion    <= DIR_SUBE;
            luces_cabina <= '0;
            luces_sube   <= '0;
            luces_baja   <= '0;
            aviso        <= '0;
        end else begin
            estado       <= estado_sig;
            piso_actual  <= piso_sig;
            direccion    <= dir_sig;
            luces_cabina <= emerg ? '0 : ((luces_cabina | (llamada_cabina & ~bloq_cab)) & ~limpia_cab);
            luces_sube   <= emerg ? '0 : ((luces_sube | (llamada_sube & MASCARA_SUBE & ~bloq_sube)) & ~limpia_sube);
            luces_baja   <= emerg ? '0 : ((luces_baja | (llamada_baja & MASCARA_BAJA & ~bloq_baja)) & ~limpia_baja);
            aviso        <= entra_servicio ? oh_eval : '0;
        end
    end

    // Door and motion indications follow the state directly.
    always_comb begin
        moviendo = (estado == MOVIENDO);
        case (estado)
            ABRIENDO: puertas = PUERTAS_ABRIENDO;
            ABIERTA:  puertas = PUERTAS_ABIERTAS;
            CERRANDO: puertas = PUERTAS_CERRANDO;
            default:  puertas = PUERTAS_CERRADAS;
        endcase
    end

endmodule
